// File: rtl/ysyx_25030093_csr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25030093_csr_pkg
// Brief    : Shared constants for the machine-mode CSR unit: CSR addresses,
//            csr_op encodings and mstatus field positions.
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_25030093_csr_pkg;

  // Supported CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;

  // csr_op encodings
  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  // mstatus field positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;

endpackage
`default_nettype wire

// File: rtl/ysyx_25030093_csr_file_if.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25030093_csr_file_if
// Brief    : CSR access bus between the EXU/WBU stage and the CSR unit.
// Revision : 1.0 - initial release
// ============================================================================
interface ysyx_25030093_csr_file_if #(
  parameter int XLEN = 32
);
  logic            csr_valid;
  logic [11:0]     csr_addr;
  logic [1:0]      csr_op;
  logic [XLEN-1:0] csr_wsrc;
  logic            csr_wsrc_zero;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;

  // Instruction side: issues the access, receives old value and legality
  modport master (
    output csr_valid, csr_addr, csr_op, csr_wsrc, csr_wsrc_zero,
    input  csr_rdata, csr_illegal
  );

  // CSR unit side
  modport slave (
    input  csr_valid, csr_addr, csr_op, csr_wsrc, csr_wsrc_zero,
    output csr_rdata, csr_illegal
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_25030093_csr_counter64.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25030093_csr_counter64
// Brief    : Two-half free-running counter with per-half overwrite. A write
//            to either half discards that cycle's increment entirely.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25030093_csr_counter64 #(
  parameter int HALF_W = 32
) (
  input  wire logic              clock,
  input  wire logic              reset,
  input  wire logic              i_inc,
  input  wire logic              i_wr_lo,
  input  wire logic              i_wr_hi,
  input  wire logic [HALF_W-1:0] i_wdata,
  output logic      [HALF_W-1:0] o_rdata_lo,
  output logic      [HALF_W-1:0] o_rdata_hi
);
  localparam logic [2*HALF_W-1:0] c_one = {{(2*HALF_W-1){1'b0}}, 1'b1};

  logic [2*HALF_W-1:0] r_count;

  // Half overwrite wins over increment; the untouched half is held
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_wr_lo || i_wr_hi) begin
      if (i_wr_lo) r_count[HALF_W-1:0]        <= i_wdata;
      if (i_wr_hi) r_count[2*HALF_W-1:HALF_W] <= i_wdata;
    end else if (i_inc) begin
      r_count <= r_count + c_one;
    end
  end

  assign o_rdata_lo = r_count[HALF_W-1:0];
  assign o_rdata_hi = r_count[2*HALF_W-1:HALF_W];
endmodule
`default_nettype wire

// File: rtl/ysyx_25030093_csr_file.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_25030093_csr_file
// Brief    : Machine-mode CSR unit: CSR read/modify/write, trap entry and
//            mret sequencing, mcycle/minstret counters, registered PC
//            redirect towards the IFU.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_25030093_csr_file
  import ysyx_25030093_csr_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET  = 32'h0000_0000,
  parameter logic [XLEN-1:0] MVENDORID    = 32'h7973_7978,
  parameter logic [XLEN-1:0] MARCHID      = 32'd25030093,
  parameter int              HAS_MINSTRET = 1
) (
  input  wire logic            clock,
  input  wire logic            reset,
  ysyx_25030093_csr_file_if.slave csr,
  input  wire logic            trap_valid,
  input  wire logic [XLEN-1:0] trap_cause,
  input  wire logic [XLEN-1:0] trap_pc,
  input  wire logic [XLEN-1:0] trap_tval,
  input  wire logic            mret_valid,
  input  wire logic            instret_inc,
  output logic                 redirect_valid,
  output logic      [XLEN-1:0] redirect_pc,
  output logic                 mstatus_mie
);
  // Architectural state; mstatus keeps only its two writable bits
  logic            r_mie, r_mpie;
  logic [XLEN-1:0] r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_pc;

  logic [XLEN-1:0] w_mstatus, w_old, w_wval;
  logic [XLEN-1:0] w_mcycle_lo, w_mcycle_hi, w_minstret_lo, w_minstret_hi;
  logic            w_known, w_read_only, w_write_attempt, w_illegal, w_write_en;
  csr_op_e         w_op;

  assign w_op = csr_op_e'(csr.csr_op);

  // Assemble the architectural mstatus view (MPP hardwired to M-mode)
  always_comb begin
    w_mstatus                                = '0;
    w_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    w_mstatus[MSTATUS_MPIE]                  = r_mpie;
    w_mstatus[MSTATUS_MIE]                   = r_mie;
  end

  // Address decode: old value, existence and read-only attribute
  always_comb begin
    w_old       = '0;
    w_known     = 1'b1;
    w_read_only = 1'b0;
    case (csr.csr_addr)
      CSR_MSTATUS:   w_old = w_mstatus;
      CSR_MTVEC:     w_old = r_mtvec;
      CSR_MSCRATCH:  w_old = r_mscratch;
      CSR_MEPC:      w_old = r_mepc;
      CSR_MCAUSE:    w_old = r_mcause;
      CSR_MTVAL:     w_old = r_mtval;
      CSR_MCYCLE:    w_old = w_mcycle_lo;
      CSR_MCYCLEH:   w_old = w_mcycle_hi;
      CSR_MINSTRET:  if (HAS_MINSTRET != 0) w_old = w_minstret_lo; else w_known = 1'b0;
      CSR_MINSTRETH: if (HAS_MINSTRET != 0) w_old = w_minstret_hi; else w_known = 1'b0;
      CSR_MVENDORID: begin w_old = MVENDORID; w_read_only = 1'b1; end
      CSR_MARCHID:   begin w_old = MARCHID;   w_read_only = 1'b1; end
      default:       w_known = 1'b0;
    endcase
  end

  // RS/RC from x0/zimm=0 is a pure read, so it never counts as a write
  assign w_write_attempt = (w_op == CSR_OP_RW) ||
                           (((w_op == CSR_OP_RS) || (w_op == CSR_OP_RC)) && !csr.csr_wsrc_zero);
  assign w_illegal  = csr.csr_valid && (!w_known || (w_read_only && w_write_attempt));
  assign w_write_en = csr.csr_valid && w_write_attempt && !w_illegal && !trap_valid && !mret_valid;

  // Read-modify-write value before per-register field masking
  always_comb begin
    w_wval = w_old;
    case (w_op)
      CSR_OP_RW: w_wval = csr.csr_wsrc;
      CSR_OP_RS: w_wval = w_old | csr.csr_wsrc;
      CSR_OP_RC: w_wval = w_old & ~csr.csr_wsrc;
      default:   w_wval = w_old;
    endcase
  end

  assign csr.csr_rdata   = w_old;
  assign csr.csr_illegal = w_illegal;

  // Trap entry beats mret beats CSR write; redirect is a one-cycle pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mie            <= MSTATUS_RESET[MSTATUS_MIE];
      r_mpie           <= MSTATUS_RESET[MSTATUS_MPIE];
      r_mtvec          <= MTVEC_RESET;
      r_mscratch       <= '0;
      r_mepc           <= '0;
      r_mcause         <= '0;
      r_mtval          <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else if (trap_valid) begin
      r_mepc           <= {trap_pc[XLEN-1:2], 2'b00};
      r_mcause         <= trap_cause;
      r_mtval          <= trap_tval;
      r_mpie           <= r_mie;
      r_mie            <= 1'b0;
      r_redirect_valid <= 1'b1;
      r_redirect_pc    <= r_mtvec;
    end else if (mret_valid) begin
      r_mie            <= r_mpie;
      r_mpie           <= 1'b1;
      r_redirect_valid <= 1'b1;
      r_redirect_pc    <= r_mepc;
    end else begin
      r_redirect_valid <= 1'b0;
      if (w_write_en) begin
        case (csr.csr_addr)
          CSR_MSTATUS: begin
            r_mie  <= w_wval[MSTATUS_MIE];
            r_mpie <= w_wval[MSTATUS_MPIE];
          end
          CSR_MTVEC:    r_mtvec    <= {w_wval[XLEN-1:2], 2'b00};
          CSR_MSCRATCH: r_mscratch <= w_wval;
          CSR_MEPC:     r_mepc     <= {w_wval[XLEN-1:2], 2'b00};
          CSR_MCAUSE:   r_mcause   <= w_wval;
          CSR_MTVAL:    r_mtval    <= w_wval;
          default:      ;
        endcase
      end
    end
  end

  ysyx_25030093_csr_counter64 #(.HALF_W(XLEN)) u_mcycle (
    .clock      (clock),
    .reset      (reset),
    .i_inc      (1'b1),
    .i_wr_lo    (w_write_en && (csr.csr_addr == CSR_MCYCLE)),
    .i_wr_hi    (w_write_en && (csr.csr_addr == CSR_MCYCLEH)),
    .i_wdata    (w_wval),
    .o_rdata_lo (w_mcycle_lo),
    .o_rdata_hi (w_mcycle_hi)
  );

  generate
    if (HAS_MINSTRET != 0) begin : g_minstret
      ysyx_25030093_csr_counter64 #(.HALF_W(XLEN)) u_minstret (
        .clock      (clock),
        .reset      (reset),
        .i_inc      (instret_inc),
        .i_wr_lo    (w_write_en && (csr.csr_addr == CSR_MINSTRET)),
        .i_wr_hi    (w_write_en && (csr.csr_addr == CSR_MINSTRETH)),
        .i_wdata    (w_wval),
        .o_rdata_lo (w_minstret_lo),
        .o_rdata_hi (w_minstret_hi)
      );
    end else begin : g_no_minstret
      assign w_minstret_lo = '0;
      assign w_minstret_hi = '0;
    end
  endgenerate

  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign mstatus_mie    = r_mie;
endmodule
`default_nettype wire
